// File: rtl/front_panel_pkg.sv
// Shared types for the SLC-3 front-panel script sequencer.
// Pure declarations, no timing.
// No flow control.
package front_panel_pkg;

    localparam int ENTRY_W = 32;
    localparam int ARG_W   = 10;
    localparam int COUNT_W = 18;

    // Script opcodes; encodings 8-15 are illegal and trap to DONE.
    typedef enum logic [3:0] {
        OP_END          = 4'd0,
        OP_SET_SW       = 4'd1,
        OP_PULSE_RUN    = 4'd2,
        OP_PULSE_CONT   = 4'd3,
        OP_WAIT         = 4'd4,
        OP_WAIT_PAUSE   = 4'd5,
        OP_EXPECT_LED   = 4'd6,
        OP_WAIT_RELEASE = 4'd7
    } op_e;

    // op is kept as a raw nibble so illegal encodings survive the latch.
    typedef struct packed {
        logic [3:0]         op;
        logic [ARG_W-1:0]   arg;
        logic [COUNT_W-1:0] count;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_PULSE,
        S_WAIT,
        S_WAIT_PAUSE,
        S_WAIT_RELEASE,
        S_DONE
    } state_e;

    function automatic entry_t mk_entry(op_e op, logic [ARG_W-1:0] arg,
                                        logic [COUNT_W-1:0] count);
        entry_t e;
        e.op    = op;
        e.arg   = arg;
        e.count = count;
        return e;
    endfunction

    function automatic logic [7:0] sat_inc8(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/seq_script_rom.sv
// Combinational script table feeding the front-panel sequencer.
// Zero latency: data_o follows addr_i in the same cycle.
// No flow control; unlisted addresses read as END.
module seq_script_rom
    import front_panel_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    output logic [ENTRY_W-1:0]       data_o
);

    // Default session: load switches, press Run, stop.
    always_comb begin
        data_o = mk_entry(OP_END, '0, '0);
        case (int'(addr_i))
            0:       data_o = mk_entry(OP_SET_SW, 10'h05A, 18'd0);
            1:       data_o = mk_entry(OP_PULSE_RUN, 10'h000, 18'd0);
            2:       data_o = mk_entry(OP_END, 10'h000, 18'd0);
            default: data_o = mk_entry(OP_END, 10'h000, 18'd0);
        endcase
    end

endmodule

// File: rtl/front_panel_sequencer.sv
// Scripted front-panel operator: drives SW/Run/Continue from a script, checks LEDs.
// Each entry costs FETCH+EXEC (2 cycles) plus any pulse/wait cycles; outputs registered.
// No backpressure; waits on Paused are bounded by the entry count (0 = forever).
module front_panel_sequencer
    import front_panel_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Paused,
    input  logic [9:0]               LED,
    output logic [$clog2(DEPTH)-1:0] Script_Addr,
    input  logic [ENTRY_W-1:0]       Script_Data,
    output logic [9:0]               SW,
    output logic                     Run,
    output logic                     Continue,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Pass,
    output logic [7:0]               Err_Count,
    output logic                     Timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]      LAST_PC   = AW'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] PULSE_LEN = COUNT_W'(PULSE_CYCLES);
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    state_e             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    entry_t             ir_q, ir_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]         sw_q, sw_d;
    logic               run_q, run_d;
    logic               cont_q, cont_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [7:0]         err_q, err_d;
    logic               tmo_q, tmo_d;
    logic               adv;
    logic               cond_met;

    // State and output registers; reset also releases any held button.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            sw_q    <= '0;
            run_q   <= 1'b1;
            cont_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            run_q   <= run_d;
            cont_q  <= cont_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: per-state actions, then a shared "advance" that stops at the last entry.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        sw_d     = sw_q;
        run_d    = run_q;
        cont_d   = cont_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        adv      = 1'b0;
        cond_met = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    pc_d    = '0;
                    err_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                ir_d    = Script_Data;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (ir_q.op)
                    OP_END: state_d = S_DONE;
                    OP_SET_SW: begin
                        sw_d = ir_q.arg;
                        adv  = 1'b1;
                    end
                    OP_PULSE_RUN: begin
                        run_d   = 1'b0;
                        cnt_d   = PULSE_LEN;
                        state_d = S_PULSE;
                    end
                    OP_PULSE_CONT: begin
                        cont_d  = 1'b0;
                        cnt_d   = PULSE_LEN;
                        state_d = S_PULSE;
                    end
                    OP_WAIT: begin
                        if (ir_q.count == '0) begin
                            adv = 1'b1;
                        end else begin
                            cnt_d   = ir_q.count;
                            state_d = S_WAIT;
                        end
                    end
                    OP_WAIT_PAUSE: begin
                        cnt_d   = ir_q.count;
                        state_d = S_WAIT_PAUSE;
                    end
                    OP_EXPECT_LED: begin
                        if (LED != ir_q.arg) begin
                            err_d = sat_inc8(err_q);
                        end
                        adv = 1'b1;
                    end
                    OP_WAIT_RELEASE: begin
                        cnt_d   = ir_q.count;
                        state_d = S_WAIT_RELEASE;
                    end
                    default: begin
                        err_d   = sat_inc8(err_q);
                        state_d = S_DONE;
                    end
                endcase
            end

            S_PULSE: begin
                if (cnt_q == CNT_ONE) begin
                    run_d  = 1'b1;
                    cont_d = 1'b1;
                    adv    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    adv = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_WAIT_PAUSE, S_WAIT_RELEASE: begin
                // A satisfied condition wins over an expiring timeout in the same cycle.
                cond_met = (state_q == S_WAIT_PAUSE) ? Paused : !Paused;
                if (cond_met) begin
                    adv = 1'b1;
                end else if (ir_q.count != '0) begin
                    if (cnt_q == CNT_ONE) begin
                        tmo_d   = 1'b1;
                        err_d   = sat_inc8(err_q);
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (pc_q == LAST_PC) begin
                state_d = S_DONE;
            end else begin
                pc_d    = pc_q + AW'(1);
                state_d = S_FETCH;
            end
        end
    end

    // Status flags follow the upcoming state so they line up with it.
    always_comb begin
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 8'd0) && !tmo_d;
    end

    assign Script_Addr = pc_q;
    assign SW          = sw_q;
    assign Run         = run_q;
    assign Continue    = cont_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Pass        = pass_q;
    assign Err_Count   = err_q;
    assign Timeout     = tmo_q;

endmodule

// File: tb/tb_front_panel_sequencer.sv
module tb_front_panel_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Start4;
    logic        Paused;
    logic [9:0]  LED;
    logic        use_rom;

    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] rom_data;
    logic [9:0]  sw;
    logic        run, cont, busy, done, pass, tmo;
    logic [7:0]  err;

    logic [1:0]  addr4;
    logic [31:0] data4;
    logic [9:0]  sw4;
    logic        run4, cont4, busy4, done4, pass4, tmo4;
    logic [7:0]  err4;

    logic [31:0] mem  [32];
    logic [31:0] mem4 [4];

    int checks = 0;
    int errors = 0;

    assign data  = use_rom ? rom_data : mem[addr];
    assign data4 = mem4[addr4];

    front_panel_sequencer #(.DEPTH(32), .PULSE_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Paused(Paused), .LED(LED),
        .Script_Addr(addr), .Script_Data(data), .SW(sw), .Run(run),
        .Continue(cont), .Busy(busy), .Done(done), .Pass(pass),
        .Err_Count(err), .Timeout(tmo)
    );

    seq_script_rom #(.DEPTH(32)) rom (.addr_i(addr), .data_o(rom_data));

    front_panel_sequencer #(.DEPTH(4), .PULSE_CYCLES(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start4), .Paused(Paused), .LED(LED),
        .Script_Addr(addr4), .Script_Data(data4), .SW(sw4), .Run(run4),
        .Continue(cont4), .Busy(busy4), .Done(done4), .Pass(pass4),
        .Err_Count(err4), .Timeout(tmo4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] ent(int op, int arg, int cnt);
        logic [3:0]  o = 4'(op);
        logic [9:0]  a = 10'(arg);
        logic [17:0] c = 18'(cnt);
        return {o, a, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Returns number of ticks until Done; an expired budget is a failed check.
    task automatic wait_done(input string tag, input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        if (!done) check({tag, "_done_budget"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, t1, t2, run_low, run_falls, cont_low, rel_at;
        logic prev_cont, prev_run;

        Reset = 1'b1; Start = 1'b0; Start4 = 1'b0; Paused = 1'b0;
        LED = '0; use_rom = 1'b1;
        clear_mem();
        for (int i = 0; i < 4; i++) mem4[i] = 32'h0;
        tick(); tick();

        // Reset state
        check("rst_sw", sw, 0);
        check("rst_run", run, 1);
        check("rst_cont", cont, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err, 0);
        check("rst_tmo", tmo, 0);
        check("rst_addr", addr, 0);
        Reset = 1'b0;
        tick();

        // 1: ROM script SET_SW 0x05A, PULSE_RUN, END
        start_pulse();
        check("t1_busy", busy, 1);
        tick();
        check("t1_sw_fetch", sw, 0);
        tick();
        check("t1_sw_exec", sw, 10'h05A);
        run_low = 0; run_falls = 0; cont_low = 0; prev_run = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (!run) run_low++;
            if (!run && prev_run) run_falls++;
            if (!cont) cont_low++;
            prev_run = run;
        end
        check("t1_run_low", run_low, 4);
        check("t1_run_falls", run_falls, 1);
        check("t1_cont_low", cont_low, 0);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_busy_end", busy, 0);
        use_rom = 1'b0;

        // 2: SET_SW 1, WAIT 10, SET_SW 2, END
        clear_mem();
        mem[0] = ent(1, 1, 0); mem[1] = ent(4, 0, 10); mem[2] = ent(1, 2, 0);
        start_pulse();
        t1 = -1; t2 = -1;
        for (int k = 1; k <= 200 && !done; k++) begin
            tick();
            if (sw == 10'h001 && t1 < 0) t1 = k;
            if (sw == 10'h002 && t2 < 0) t2 = k;
        end
        check("t2_sw_gap", t2 - t1, 14);
        check("t2_pass", pass, 1);

        // 3: WAIT_PAUSE 1000, SET_SW 3, PULSE_CONT, WAIT_RELEASE 100, END
        clear_mem();
        mem[0] = ent(5, 0, 1000); mem[1] = ent(1, 3, 0); mem[2] = ent(3, 0, 0);
        mem[3] = ent(7, 0, 100);
        start_pulse();
        rel_at = -1; cont_low = 0; run_low = 0; prev_cont = 1'b1;
        for (int k = 1; k <= 400 && !done; k++) begin
            if (k == 50) Paused = 1'b1;
            if (k == rel_at) Paused = 1'b0;
            tick();
            if (!cont) begin
                cont_low++;
                if (prev_cont) check("t3_sw_before_cont", sw, 10'h003);
            end
            if (cont && !prev_cont) rel_at = k + 3;
            if (!run) run_low++;
            prev_cont = cont;
        end
        Paused = 1'b0;
        check("t3_done", done, 1);
        check("t3_cont_low", cont_low, 4);
        check("t3_run_low", run_low, 0);
        check("t3_pass", pass, 1);
        check("t3_tmo", tmo, 0);

        // 4: WAIT_PAUSE 20 with Paused low -> timeout
        clear_mem();
        mem[0] = ent(5, 0, 20);
        start_pulse();
        wait_done("t4", 100, n);
        check("t4_cycles", n, 22);
        check("t4_tmo", tmo, 1);
        check("t4_err", err, 1);
        check("t4_pass", pass, 0);
        tick(); tick(); tick();
        check("t4_done_hold", done, 1);
        check("t4_no_fetch", addr, 0);

        // 5: EXPECT_LED 3, EXPECT_LED 2, END; LED=2 then LED=3
        clear_mem();
        mem[0] = ent(6, 3, 0); mem[1] = ent(6, 2, 0);
        LED = 10'h002;
        start_pulse();
        check("t5a_tmo_cleared", tmo, 0);
        wait_done("t5a", 50, n);
        check("t5a_err", err, 1);
        check("t5a_pass", pass, 0);
        LED = 10'h003;
        start_pulse();
        check("t5b_err_cleared", err, 0);
        check("t5b_done_cleared", done, 0);
        wait_done("t5b", 50, n);
        check("t5b_err", err, 1);
        check("t5b_pass", pass, 0);

        // illegal opcode traps to DONE with an error
        clear_mem();
        mem[0] = ent(9, 0, 0); mem[1] = ent(1, 10'h3FF, 0);
        start_pulse();
        wait_done("t5c", 20, n);
        check("t5c_err", err, 1);
        check("t5c_addr", addr, 0);

        // 6: reset in the 2nd cycle of PULSE_CONT
        clear_mem();
        mem[0] = ent(1, 7, 0); mem[1] = ent(3, 0, 0);
        start_pulse();
        n = 0;
        while (cont && n < 20) begin
            tick();
            n++;
        end
        check("t6_cont_seen_low", cont, 0);
        tick();
        check("t6_cont_low_2nd", cont, 0);
        check("t6_run_idle", run, 1);
        Reset = 1'b1;
        tick();
        check("t6_rst_cont", cont, 1);
        check("t6_rst_sw", sw, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_addr", addr, 0);
        Reset = 1'b0;
        tick();
        start_pulse();
        cont_low = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (!cont) cont_low++;
        end
        check("t6_rerun_sw", sw, 10'h007);
        check("t6_rerun_cont_low", cont_low, 4);
        check("t6_rerun_pass", pass, 1);

        // DEPTH=4 script without END stops after entry 3
        mem4[0] = ent(1, 1, 0); mem4[1] = ent(1, 2, 0);
        mem4[2] = ent(1, 3, 0); mem4[3] = ent(1, 4, 0);
        Start4 = 1'b1;
        tick();
        Start4 = 1'b0;
        n = 0;
        while (!done4 && n < 50) begin
            tick();
            n++;
        end
        check("d4_cycles", n, 8);
        check("d4_done", done4, 1);
        check("d4_sw", sw4, 10'h004);
        check("d4_addr", addr4, 3);
        check("d4_pass", pass4, 1);
        tick(); tick();
        check("d4_addr_hold", addr4, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/front_panel_sequencer.md
Name: front_panel_sequencer

Overview:
Synthesizable scripted operator for the SLC-3 front panel. It drives the processor's SW, Run and Continue inputs from a small command script. It also watches the processor's pause indication and LED outputs. This lets a program-driven session (load SW, press Run, respond to each PAUSE with new SW and a Continue press, check LEDs) run on-chip or in simulation without hand-timed stimulus.

Parameters:
DEPTH, 32, number of script entries; the address width is $clog2(DEPTH).
PULSE_CYCLES, 4, number of cycles a Run/Continue press is held low; must be at least 1.

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  level; begins the script from entry 0 when the block is in IDLE or DONE
Paused  in  1  high while the processor sits in a PAUSE state
LED  in  10  processor LED outputs
Script_Addr  out  $clog2(DEPTH)  script entry index; equals the internal pc
Script_Data  in  32  entry at Script_Addr; combinational read, valid the same cycle
SW  out  10  switch value presented to the processor
Run  out  1  active-low Run button
Continue  out  1  active-low Continue button
Busy  out  1  high in every state except IDLE and DONE
Done  out  1  script finished
Pass  out  1  valid while Done: no errors and no timeout
Err_Count  out  8  saturating error counter
Timeout  out  1  a wait operation expired

Behaviour:
- Reset values, effective on the first edge with Reset high: SW=0, Run=1, Continue=1, Busy=0, Done=0, Pass=0, Err_Count=0, Timeout=0, pc=0, state IDLE. Reset mid-operation releases any held button on that same edge.
- All outputs are registered.
- Entry format: [31:28] op, [27:18] arg (10 bits), [17:0] count (18 bits).
- States: IDLE, FETCH, EXEC, PULSE, WAIT, WAIT_PAUSE, WAIT_RELEASE, DONE.
- IDLE/DONE + Start: pc=0, clear Err_Count, Timeout, Done and Pass, then go to FETCH. Start is ignored while Busy.
- FETCH (1 cycle): latch Script_Data into the instruction register, then go to EXEC.
- "Advance" means pc++ then FETCH. If pc==DEPTH-1, advance goes to DONE instead (implicit end; pc never wraps).
- EXEC, by op:
  0 END: go to DONE.
  1 SET_SW: SW<=arg, then advance.
  2 PULSE_RUN: Run<=0, counter<=PULSE_CYCLES, go to PULSE.
  3 PULSE_CONT: Continue<=0, counter<=PULSE_CYCLES, go to PULSE.
  4 WAIT: if count==0, advance. Otherwise counter<=count and go to WAIT.
  5 WAIT_PAUSE: counter<=count and go to WAIT_PAUSE.
  6 EXPECT_LED: if LED!=arg, Err_Count++. Then advance.
  7 WAIT_RELEASE: counter<=count and go to WAIT_RELEASE.
  8-15 illegal: Err_Count++ and go to DONE.
- PULSE: if counter==1, release both buttons and advance; otherwise counter--. The button is therefore low for exactly PULSE_CYCLES cycles. At most one button is low at any time.
- WAIT: if counter==1, advance; otherwise counter--. WAIT therefore occupies exactly count cycles.
- WAIT_PAUSE: Paused is sampled each cycle. If Paused==1, advance with no timeout check that cycle.
  - Otherwise, if count!=0 and counter==1: Timeout<=1, Err_Count++, go to DONE.
  - Otherwise counter-- (no decrement when count==0, i.e. wait forever).
- WAIT_RELEASE: identical to WAIT_PAUSE, but the condition is Paused==0.
- DONE: Done=1 and Pass=(Err_Count==0 && !Timeout). Outputs hold, and SW keeps its last value, until Start or Reset.
- Err_Count saturates at 255.
- Per-entry cost: FETCH+EXEC = 2 cycles, plus any PULSE/WAIT cycles.

Decomposition:
- Package front_panel_pkg:
  - op_e enum (END..WAIT_RELEASE).
  - entry_t packed struct {op, arg, count}.
  - Constants ENTRY_W=32, ARG_W=10, COUNT_W=18.
- Sub-module seq_script_rom:
  - Combinational case-table ROM, parameterized by DEPTH.
  - Instantiated alongside the sequencer and connected through Script_Addr/Script_Data.
  - Keeps scripts swappable per test program.

Test Plan:
1. Script [SET_SW 0x05A, PULSE_RUN, END], Start pulse -> SW=0x05A after the first EXEC; Run low exactly 4 consecutive cycles; Continue stays 1; then Done=1, Pass=1, Busy=0.
2. [SET_SW 0x001, WAIT 10, SET_SW 0x002, END] -> the SW change to 0x002 occurs exactly 14 cycles after the change to 0x001.
3. [WAIT_PAUSE 1000, SET_SW 0x003, PULSE_CONT, WAIT_RELEASE 100, END], Paused rises 50 cycles after Start and falls 3 cycles after Continue returns high -> SW=0x003 before Continue goes low; Continue low 4 cycles; Pass=1, Timeout=0.
4. [WAIT_PAUSE 20, END], Paused held 0 -> Timeout=1, Err_Count=1, Done=1, Pass=0, with no further fetches.
5. [EXPECT_LED 0x003, EXPECT_LED 0x002, END] with LED=0x002 -> Err_Count=1, Pass=0. A second run with LED=0x003 -> Start clears Err_Count, and the run again finishes with Err_Count=1.
6. Reset high during the 2nd cycle of a PULSE_CONT -> next edge Continue=1, SW=0, Busy=0, state IDLE. A later Start refetches entry 0. A script with no END and DEPTH=4 -> Done after entry 3.
